bdcmotor_channel_gen: RTL
=========================

Name: bdcmotor_channel_gen

Overview:
Parametrised next-generation brushed DC motor channel. Provides a quadrature tach counter with configurable width, filter depth and snapshot freeze, plus a configurable-width PWM. The PWM adds shadowed duty loading, latched cycle-by-cycle current limit, programmable dead time and H-bridge steering. One instance per motor; all strobes come from the host register and prescaler logic.

Parameters:
COUNT_WIDTH, 16, tach counter and snapshot width (2..32)
PWM_WIDTH, 8, PWM counter and duty width (4..16)
FILTER_DEPTH, 3, tach filter shift-register length (2..8)
DT_WIDTH, 4, dead-time count width

Ports:
clk  in  1  system clock
reset  in  1  asynchronous active-high reset
filterce  in  1  tach filter sample enable
freeze  in  1  hold count snapshot (host read)
invphase  in  1  invert count direction
tach  in  2  quadrature inputs {B,A}, asynchronous
count  out  COUNT_WIDTH  tach count snapshot
tacherr  out  1  sticky illegal-transition flag
pwmcntce  in  1  PWM counter advance enable
pwmldce  in  1  load wrtdata into duty shadow
wrtdata  in  PWM_WIDTH  duty value
invertpwm  in  1  invert all PWM outputs
enablepwm  in  1  0 = all drives inactive
run  in  1  0 = brake
dir  in  1  H-bridge direction
currentlimit  in  1  terminate current on-phase
deadtime  in  DT_WIDTH  dead time, in clk cycles
pwmout  out  2  {high, low} complementary half-bridge drive
pwmout4  out  4  {AH, AL, BH, BL} full-bridge drive

Behaviour:
- Reset values: count=0, tacherr=0, internal counter=0, filter state=00, PWM counter=0, duty shadow and active duty=0, limit latch=0, dead-time counter=0.
- Reset values at the ports: pwmout={2{invertpwm}} and pwmout4={4{invertpwm}}. The inversion is a final XOR stage applied after the output registers.
- Tach input path:
  - 2-flop synchroniser per input.
  - On each filterce, shift the synchronised value into a FILTER_DEPTH-long shift register.
  - The filtered value updates only when all stages agree; otherwise it holds.
- Quadrature decode, applied when the filtered value changes:
  - Gray step 00→01→11→10→00 counts +1 (−1 if invphase=1). The reverse sequence counts −1 (+1 if invphase=1).
  - If both bits change at once: no count, tacherr←1.
  - The counter wraps modulo 2^COUNT_WIDTH in both directions.
- Snapshot:
  - While freeze=0, count←counter every cycle (1-cycle latency).
  - While freeze=1, count holds. The internal counter keeps counting.
  - The freeze 0→1 edge clears tacherr, unless an illegal transition occurs in that same cycle, in which case the set wins.
- PWM counter:
  - Increments on pwmcntce and wraps 2^PWM_WIDTH−1→0.
  - Period start = a cycle where pwmcntce=1 and the counter wraps to 0.
- Duty loading:
  - pwmldce writes wrtdata to the shadow register.
  - At period start, shadow→active duty and the limit latch clears.
  - If pwmldce and period start coincide, the old shadow is transferred and the new value goes to the shadow.
- Raw drive:
  - raw=1 when counter<active duty and the limit latch is 0.
  - duty=0 gives always off; duty=2^PWM_WIDTH−1 gives on for all but one count.
- Current limit: currentlimit=1 while raw=1 sets the limit latch. The latch forces raw=0 until the next period start.
- Dead time:
  - On any raw edge, both high and low drives go inactive for `deadtime` clk cycles, then the new state is applied.
  - deadtime=0 means no gap, with 1-cycle register latency.
  - A new edge during the gap restarts the gap.
- Output priority (before inversion): reset > enablepwm=0 > run=0 > normal.
  - enablepwm=0: pwmout=00, pwmout4=0000.
  - run=0 (brake): pwmout=01, pwmout4=0101. Dead time still applies when leaving brake.
  - Normal, dir=0: AH=hi, AL=lo, BH=0, BL=1.
  - Normal, dir=1: AH=0, AL=1, BH=hi, BL=lo.
- A dir change takes effect at the next period start only.
- invertpwm XORs all six outputs combinationally.
- Reset mid-cycle: all state returns to reset values immediately; the dead-time gap is abandoned.

Optional Feature:
TACH_PERIOD_EN:
- Defined: adds output `period [COUNT_WIDTH-1:0]`, reset 0.
  - A clk-cycle counter saturates at all-ones.
  - On each legal decoded step, period←counter value, then the counter restarts from 1.
  - period follows the same freeze snapshot rule as count.
- Undefined: the port and its logic are absent.

Test Plan:
- Reset, FILTER_DEPTH=3, invphase=0, feed 8 forward gray steps, each held ≥3 filterce → count=8; repeat with invphase=1 → count=0.
- Count=0, one reverse step → count=2^COUNT_WIDTH−1 (wrap); tach 00→11 → count unchanged, tacherr=1; freeze 0→1 → tacherr=0.
- freeze=1, 5 forward steps → count holds; freeze=0 → count advances by 5 one cycle later.
- PWM_WIDTH=8, pwmcntce every cycle, deadtime=0, load 64 → pwmout[1] high 64 of 256 counts per period, applied from the next period start; a mid-period load of 128 takes effect only at the following period start.
- Duty 200, pulse currentlimit at count 50 → high side off from count ~51 until period start; next period high 200 again.
- deadtime=3, duty 64 → exactly 3 cycles with pwmout=00 at each raw edge; run=0 → 01 (pwmout4=0101); enablepwm=0 → 00; invertpwm=1 → all six outputs inverted.

Source files
------------

// File: rtl/bdcmotor_channel_gen.sv
// Brushed DC motor channel: filtered quadrature tach counter with freezable snapshot, and a
// shadowed PWM with latched current limit, dead time and H-bridge steering. Define TACH_PERIOD_EN for the step-period output.
module bdcmotor_channel_gen #(
  parameter int COUNT_WIDTH  = 16,
  parameter int PWM_WIDTH    = 8,
  parameter int FILTER_DEPTH = 3,
  parameter int DT_WIDTH     = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   filterce,
  input  logic                   freeze,
  input  logic                   invphase,
  input  logic [1:0]             tach,
  output logic [COUNT_WIDTH-1:0] count,
  output logic                   tacherr,
`ifdef TACH_PERIOD_EN
  output logic [COUNT_WIDTH-1:0] period,
`endif
  input  logic                   pwmcntce,
  input  logic                   pwmldce,
  input  logic [PWM_WIDTH-1:0]   wrtdata,
  input  logic                   invertpwm,
  input  logic                   enablepwm,
  input  logic                   run,
  input  logic                   dir,
  input  logic                   currentlimit,
  input  logic [DT_WIDTH-1:0]    deadtime,
  output logic [1:0]             pwmout,
  output logic [3:0]             pwmout4
);

  localparam logic [COUNT_WIDTH-1:0] CNT_ONE = 1;
  localparam logic [PWM_WIDTH-1:0]   PWM_ONE = 1;
  localparam logic [DT_WIDTH-1:0]    DT_ONE  = 1;

  // ---------------- tach path ----------------
  logic [1:0]                    sync1, sync2, filt;
  logic [FILTER_DEPTH-1:0][1:0]  fsr;
  logic [COUNT_WIDTH-1:0]        counter;
  logic                          freeze_d;
  logic                          agree, change, illegal, cnt_up, cnt_dn;
  logic [1:0]                    delta;

  // Gray position 00,01,11,10 -> 0,1,2,3 so a legal step is a +/-1 difference.
  function automatic logic [1:0] g2b(input logic [1:0] g);
    return {g[1], g[1] ^ g[0]};
  endfunction

  always_comb begin
    agree = 1'b1;
    for (int i = 1; i < FILTER_DEPTH; i++)
      if (fsr[i] != fsr[0]) agree = 1'b0;
    change  = agree && (fsr[0] != filt);
    delta   = g2b(fsr[0]) - g2b(filt);
    illegal = change && (delta == 2'd2);
    cnt_up  = change && (((delta == 2'd1) && !invphase) || ((delta == 2'd3) && invphase));
    cnt_dn  = change && (((delta == 2'd3) && !invphase) || ((delta == 2'd1) && invphase));
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1    <= 2'b00;
      sync2    <= 2'b00;
      fsr      <= '0;
      filt     <= 2'b00;
      counter  <= '0;
      count    <= '0;
      tacherr  <= 1'b0;
      freeze_d <= 1'b0;
    end else begin
      sync1    <= tach;
      sync2    <= sync1;
      if (filterce) fsr <= {fsr[FILTER_DEPTH-2:0], sync2};
      if (change) filt <= fsr[0];
      if (cnt_up)      counter <= counter + CNT_ONE;
      else if (cnt_dn) counter <= counter - CNT_ONE;
      if (!freeze) count <= counter;
      freeze_d <= freeze;
      if (illegal)                  tacherr <= 1'b1;
      else if (freeze && !freeze_d) tacherr <= 1'b0;
    end
  end

`ifdef TACH_PERIOD_EN
  logic [COUNT_WIDTH-1:0] per_cnt, per_lat;
  logic                   legal_step;
  assign legal_step = cnt_up || cnt_dn;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      per_cnt <= '0;
      per_lat <= '0;
      period  <= '0;
    end else begin
      if (legal_step) begin
        per_lat <= per_cnt;
        per_cnt <= CNT_ONE;
      end else if (!(&per_cnt)) begin
        per_cnt <= per_cnt + CNT_ONE;
      end
      if (!freeze) period <= per_lat;
    end
  end
`endif

  // ---------------- PWM path ----------------
  logic [PWM_WIDTH-1:0] pwm_cnt, shadow, active;
  logic                 limit, dir_act, period_start, raw, drive;
  logic                 d_prev, dprev_n, hi_n, lo_n;
  logic [DT_WIDTH-1:0]  dt_cnt, dt_n;
  logic [1:0]           out2_q;
  logic [3:0]           out4_q;

  assign period_start = pwmcntce && (&pwm_cnt);
  assign raw          = (pwm_cnt < active) && !limit;
  assign drive        = run && raw;

  // Any change of the high-side request opens a gap of deadtime cycles with both sides off.
  always_comb begin
    dprev_n = d_prev;
    dt_n    = dt_cnt;
    hi_n    = d_prev;
    lo_n    = !d_prev;
    if (drive != d_prev) begin
      dprev_n = drive;
      if (deadtime == '0) begin
        hi_n = drive;
        lo_n = !drive;
        dt_n = '0;
      end else begin
        hi_n = 1'b0;
        lo_n = 1'b0;
        dt_n = deadtime;
      end
    end else if (dt_cnt != '0) begin
      dt_n = dt_cnt - DT_ONE;
      if (dt_cnt != DT_ONE) begin
        hi_n = 1'b0;
        lo_n = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pwm_cnt <= '0;
      shadow  <= '0;
      active  <= '0;
      limit   <= 1'b0;
      dir_act <= 1'b0;
      d_prev  <= 1'b0;
      dt_cnt  <= '0;
      out2_q  <= 2'b00;
      out4_q  <= 4'b0000;
    end else begin
      if (pwmcntce) pwm_cnt <= pwm_cnt + PWM_ONE;
      if (pwmldce)  shadow  <= wrtdata;
      if (period_start) begin
        active  <= shadow;
        dir_act <= dir;
        limit   <= 1'b0;
      end else if (currentlimit && raw) begin
        limit   <= 1'b1;
      end
      d_prev <= dprev_n;
      dt_cnt <= dt_n;
      if (!enablepwm) begin
        out2_q <= 2'b00;
        out4_q <= 4'b0000;
      end else begin
        out2_q <= {hi_n, lo_n};
        out4_q <= dir_act ? {2'b01, hi_n, lo_n} : {hi_n, lo_n, 2'b01};
      end
    end
  end

  assign pwmout  = out2_q ^ {2{invertpwm}};
  assign pwmout4 = out4_q ^ {4{invertpwm}};

endmodule
